imem_boot_loader: RTL and testbench

//  Byte-stream program loader sitting upstream of the RV32I core's instruction memory bank.
//  - Receives a framed program image over a valid/ready byte interface.
//  - Assembles little-endian 32-bit words and writes them to instruction memory from word address 0.
//  - Holds the core in reset until a checksum-verified image has been loaded.
//  - Replaces testbench hierarchical preloading with a synthesizable boot path.

---
 rtl/imem_boot_loader_pkg.sv | 22 ++
 rtl/imem_boot_loader.sv | 143 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and
// frame field widths.
package imem_boot_loader_pkg;

  localparam int unsigned CSUM_W = 8;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } boot_state_t;

  // States in which the loader takes bytes from the receive stream.
  function automatic logic accepts_byte(input boot_state_t s);
    return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: assembles a framed, checksummed image into
// little-endian words for instruction memory and releases the core when verified.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1 << ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  input  logic              i_reload,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  boot_state_t       state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       asm_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CSUM_W-1:0] sum_q;

  logic              rx_ready_q, mem_we_q, core_rst_q, done_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic              xfer;
  logic [LEN_W-1:0]  len_full;
  logic              len_too_big;
  logic              last_word;

  assign xfer        = i_rx_valid & rx_ready_q;
  assign len_full    = {i_rx_data, len_q[7:0]};
  assign len_too_big = 32'(len_full) > MAX_WORDS;
  // Word counter is one bit wider than the address so a full-size image ends cleanly.
  assign last_word   = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0: if (xfer) state_d = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (len_too_big)            state_d = S_ERR;
          else if (len_full == '0)    state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: if (xfer && (byte_idx_q == 2'd3) && last_word) state_d = S_CSUM;
      S_CSUM: if (xfer) state_d = (i_rx_data == sum_q) ? S_DONE : S_ERR;
      S_DONE, S_ERR: if (i_reload) state_d = S_LEN0;
      default: state_d = S_LEN0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_LEN0;
      len_q       <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      word_cnt_q  <= '0;
      sum_q       <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= accepts_byte(state_d);
      mem_we_q   <= 1'b0;
      if (xfer && ((state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA)))
        sum_q <= sum_q + i_rx_data;
      case (state_q)
        S_LEN0: if (xfer) len_q[7:0] <= i_rx_data;
        S_LEN1: begin
          if (xfer) begin
            len_q      <= len_full;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            if (len_too_big) err_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            asm_q      <= {i_rx_data, asm_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= {i_rx_data, asm_q};
              mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
              word_cnt_q  <= word_cnt_q + CNT_W'(1);
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (i_rx_data == sum_q) begin
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (i_reload) begin
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sum_q      <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rx_ready  = rx_ready_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_core_rst  = core_rst_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frame-level model checked every cycle, plus
// literal expectations for the directed boot scenarios.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              rx_valid, reload;
  logic [7:0]        rx_data;
  logic              rx_ready, mem_we, core_rst, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  logic              s_valid, s_reload;
  logic [7:0]        s_data;
  logic              s_ready, s_we, s_core_rst, s_done, s_err;
  logic [1:0]        s_addr;
  logic [31:0]       s_wdata;

  imem_boot_loader #(.ADDR_W(ADDR_W)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_rx_ready(rx_ready), .i_reload(reload), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_core_rst(core_rst),
    .o_done(done), .o_err(err)
  );

  imem_boot_loader #(.ADDR_W(2)) u_small (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(s_valid), .i_rx_data(s_data),
    .o_rx_ready(s_ready), .i_reload(s_reload), .o_mem_we(s_we),
    .o_mem_addr(s_addr), .o_mem_wdata(s_wdata), .o_core_rst(s_core_rst),
    .o_done(s_done), .o_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: the bytes of the current frame accepted so far.
  typedef enum {M_LOAD, M_DONE, M_ERR} mstat_t;
  logic [7:0]        mq[$];
  bit                armed;
  bit                pend_we;
  logic [ADDR_W-1:0] pend_addr, last_addr;
  logic [31:0]       pend_data;
  logic [31:0]       tb_mem [0:15];
  int                n_writes = 0;
  int                s_writes = 0;

  function automatic int m_len();
    return int'({mq[1], mq[0]});
  endfunction

  function automatic mstat_t m_status();
    int n, len, total;
    logic [7:0] s;
    n = mq.size();
    if (n < 2) return M_LOAD;
    len = m_len();
    if (len > int'(MAX_WORDS)) return M_ERR;
    total = 3 + 4 * len;
    if (n < total) return M_LOAD;
    s = '0;
    for (int i = 0; i < total - 1; i++) s = s + mq[i];
    return (s == mq[total-1]) ? M_DONE : M_ERR;
  endfunction

  always @(negedge clk) begin : mon
    mstat_t st;
    bit     exp_ready;
    int     idx, len;
    if (s_we) s_writes++;
    if (rst) begin
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_mem_we",   32'(mem_we),   32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_done",     32'(done),     32'd0);
      check("rst_err",      32'(err),      32'd0);
      mq.delete();
      armed     = 0;
      pend_we   = 0;
      last_addr = '0;
    end else begin
      st        = m_status();
      exp_ready = armed && (st == M_LOAD);
      if (pend_we) last_addr = pend_addr;
      check("rx_ready", 32'(rx_ready), 32'(exp_ready));
      check("mem_we",   32'(mem_we),   32'(pend_we));
      check("mem_addr", 32'(mem_addr), 32'(last_addr));
      if (pend_we) check("mem_wdata", mem_wdata, pend_data);
      check("done",     32'(done),     32'(st == M_DONE));
      check("err",      32'(err),      32'(st == M_ERR));
      check("core_rst", 32'(core_rst), 32'(st != M_DONE));
      if (mem_we) begin
        n_writes++;
        if (32'(mem_addr) < 32'd16) tb_mem[mem_addr[3:0]] = mem_wdata;
      end
      pend_we = 0;
      if (reload && (st != M_LOAD)) begin
        mq.delete();
      end else if (rx_valid && exp_ready) begin
        mq.push_back(rx_data);
        idx = mq.size() - 1;
        if (idx >= 2) begin
          len = m_len();
          if (len <= int'(MAX_WORDS) && idx < 2 + 4 * len && ((idx - 2) % 4) == 3) begin
            pend_we   = 1;
            pend_addr = ADDR_W'((idx - 2) / 4);
            pend_data = {mq[idx], mq[idx-1], mq[idx-2], mq[idx-3]};
          end
        end
      end
      armed = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok, r;
    idle(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      r = rx_ready;
      @(posedge clk);
      #1;
      if (r) ok = 1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_byte: byte %h not accepted within 40 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int max_gap);
    foreach (f[i]) send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    idle(1);
    reload = 1'b0;
  endtask

  logic [7:0] f1[$], f2[$], f3[$], f5[$], f6b[$];
  int w0;

  initial begin
    f1  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
    f2  = '{8'h00, 8'h00, 8'h00};
    f3  = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    f5  = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    f6b = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    for (int i = 0; i < 16; i++) tb_mem[i] = '0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; reload = 1'b0;
    s_valid = 1'b0; s_data = '0; s_reload = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Oversized length on a 4-word instance errors right after LEN_HI.
    s_valid = 1'b1; s_data = 8'h05;
    @(negedge clk); check("small_ready_len0", 32'(s_ready), 32'd1);
    @(posedge clk); #1; s_data = 8'h00;
    @(negedge clk); check("small_ready_len1", 32'(s_ready), 32'd1);
    @(posedge clk); #1; s_valid = 1'b0;
    @(negedge clk);
    check("small_err",      32'(s_err),      32'd1);
    check("small_ready",    32'(s_ready),    32'd0);
    check("small_core_rst", 32'(s_core_rst), 32'd1);
    check("small_done",     32'(s_done),     32'd0);
    idle(3);
    check("small_writes",   32'(s_writes),   32'd0);

    // Two-word image with a correct checksum.
    w0 = n_writes;
    send_frame(f1, 0);
    idle(2);
    check("c1_mem0",     tb_mem[0], 32'h0000_0013);
    check("c1_mem1",     tb_mem[1], 32'h0010_0093);
    check("c1_writes",   32'(n_writes - w0), 32'd2);
    check("c1_done",     32'(done),     32'd1);
    check("c1_core_rst", 32'(core_rst), 32'd0);
    pulse_reload();
    idle(1);

    // Empty image.
    w0 = n_writes;
    send_frame(f2, 0);
    idle(2);
    check("c2_writes", 32'(n_writes - w0), 32'd0);
    check("c2_done",   32'(done), 32'd1);
    pulse_reload();
    idle(1);

    // Bad checksum: word still written, loader errors, core held.
    w0 = n_writes;
    send_frame(f3, 0);
    idle(2);
    check("c3_mem0",     tb_mem[0], 32'hDDCC_BBAA);
    check("c3_writes",   32'(n_writes - w0), 32'd1);
    check("c3_err",      32'(err),      32'd1);
    check("c3_core_rst", 32'(core_rst), 32'd1);
    check("c3_ready",    32'(rx_ready), 32'd0);
    pulse_reload();
    idle(1);

    // Reset in the middle of a frame, then a clean load.
    send_frame(f5, 0);
    idle(1);
    check("c5_partial_mem0", tb_mem[0], 32'h4433_2211);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(f1, 0);
    idle(2);
    check("c5_mem0", tb_mem[0], 32'h0000_0013);
    check("c5_mem1", tb_mem[1], 32'h0010_0093);
    check("c5_done", 32'(done), 32'd1);

    // Gapped stream, reload, then a second image.
    pulse_reload();
    idle(1);
    send_frame(f1, 3);
    idle(2);
    check("c6_done", 32'(done), 32'd1);
    check("c6_mem1", tb_mem[1], 32'h0010_0093);
    pulse_reload();
    check("c6_reload_core_rst", 32'(core_rst), 32'd1);
    check("c6_reload_done",     32'(done),     32'd0);
    send_frame(f6b, 2);
    idle(2);
    check("c6b_mem0", tb_mem[0], 32'h0403_0201);
    check("c6b_done", 32'(done), 32'd1);
    check("c6b_core_rst", 32'(core_rst), 32'd0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
